// File: rtl/ttc_symbol_generator.sv
// ttc_symbol_generator
//   Turns rising edges on the four TTC command inputs into fixed-length
//   serial code symbols on encode_ttc. Commands are arbitrated by priority
//   (MR > BCR > ECR > TRIG). Triggers are held in a counted backlog. The
//   block also keeps the bunch-crossing counter and the event ID.
//
// Ports
//   clk_40        40 MHz clock
//   rst_40        asynchronous active-high reset
//   trigger       level input, rising edge requests a trigger symbol
//   bc_reset      level input, rising edge requests a BCR symbol
//   event_reset   level input, rising edge requests an ECR symbol
//   master_reset  level input, rising edge requests an MR symbol
//   encode_ttc    serial symbol slice, MSB slice first, 0 when idle
//   fpga_bcr      one-cycle pulse while the bunch-crossing counter is at BC_MAX
//   busy          symbol in flight or any request pending
//   trig_pending  number of queued triggers
//   trig_overflow sticky flag, a trigger was dropped on a full queue
//   evt_id        triggers sent since the last ECR/MR
module ttc_symbol_generator #(
  parameter int unsigned          ENC_W      = 2,
  parameter int unsigned          CODE_W     = 8,
  parameter logic [CODE_W-1:0]    CODE_TRIG  = 8'h81,
  parameter logic [CODE_W-1:0]    CODE_BCR   = 8'h99,
  parameter logic [CODE_W-1:0]    CODE_ECR   = 8'hA5,
  parameter logic [CODE_W-1:0]    CODE_MR    = 8'hE7,
  parameter int unsigned          BC_MAX     = 3563,
  parameter int unsigned          TRIG_DEPTH = 8,
  parameter int unsigned          EVT_W      = 12,
  parameter int unsigned          AUTO_BCR   = 0,
  parameter int unsigned          GAP        = 0
) (
  input  logic                              clk_40,
  input  logic                              rst_40,
  input  logic                              trigger,
  input  logic                              bc_reset,
  input  logic                              event_reset,
  input  logic                              master_reset,
  output logic [ENC_W-1:0]                  encode_ttc,
  output logic                              fpga_bcr,
  output logic                              busy,
  output logic [$clog2(TRIG_DEPTH+1)-1:0]   trig_pending,
  output logic                              trig_overflow,
  output logic [EVT_W-1:0]                  evt_id
);

  localparam int unsigned SLICES   = CODE_W / ENC_W;
  localparam int unsigned CNT_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned TP_W     = $clog2(TRIG_DEPTH + 1);
  localparam int unsigned BC_W     = $clog2(BC_MAX + 1);
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  shreg_q;
  logic [CNT_W-1:0]   slice_q;
  logic [GAP_W-1:0]   gap_q;
  logic [BC_W-1:0]    bc_q;
  logic               trig_d, bcr_d, ecr_d, mr_d;
  logic               mr_req, bcr_req, ecr_req;

  logic               trig_rise, bcr_rise, ecr_rise, mr_rise;
  logic               any_req, start;
  logic               start_mr, start_bcr, start_ecr, start_trig;
  logic [CODE_W-1:0]  code_sel;
  logic               tp_full, trig_acc, bc_wrap;

  assign trig_rise = trigger      & ~trig_d;
  assign bcr_rise  = bc_reset     & ~bcr_d;
  assign ecr_rise  = event_reset  & ~ecr_d;
  assign mr_rise   = master_reset & ~mr_d;

  assign any_req = mr_req | bcr_req | ecr_req | (trig_pending != '0);
  assign bc_wrap = (bc_q == BC_W'(BC_MAX));

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    start_mr   = 1'b0;
    start_bcr  = 1'b0;
    start_ecr  = 1'b0;
    start_trig = 1'b0;
    code_sel   = CODE_TRIG;
    case (state_q)
      S_IDLE: start = any_req;
      S_SEND: begin
        if (slice_q == CNT_W'(SLICES - 1)) begin
          if (GAP > 0)      state_d = S_GAP;
          else if (any_req) start   = 1'b1;
          else              state_d = S_IDLE;
        end
      end
      // The final gap cycle loads a waiting symbol itself, so exactly GAP
      // zero cycles separate back-to-back symbols.
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          if (any_req) start   = 1'b1;
          else         state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_SEND;
      if (mr_req) begin
        start_mr = 1'b1;
        code_sel = CODE_MR;
      end else if (bcr_req) begin
        start_bcr = 1'b1;
        code_sel  = CODE_BCR;
      end else if (ecr_req) begin
        start_ecr = 1'b1;
        code_sel  = CODE_ECR;
      end else begin
        start_trig = 1'b1;
        code_sel   = CODE_TRIG;
      end
    end
  end

  // A rise arriving while the queue is full is still accepted when a
  // trigger symbol starts in the same cycle.
  assign tp_full  = (trig_pending == TP_W'(TRIG_DEPTH));
  assign trig_acc = trig_rise & (~tp_full | start_trig);

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      trig_d <= 1'b0;
      bcr_d  <= 1'b0;
      ecr_d  <= 1'b0;
      mr_d   <= 1'b0;
    end else begin
      trig_d <= trigger;
      bcr_d  <= bc_reset;
      ecr_d  <= event_reset;
      mr_d   <= master_reset;
    end
  end

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      slice_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        shreg_q <= code_sel;
        slice_q <= '0;
      end else if (state_q == S_SEND) begin
        shreg_q <= shreg_q << ENC_W;
        slice_q <= slice_q + CNT_W'(1);
      end
      if (state_q == S_GAP) gap_q <= gap_q + GAP_W'(1);
      else                  gap_q <= '0;
    end
  end

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      mr_req        <= 1'b0;
      bcr_req       <= 1'b0;
      ecr_req       <= 1'b0;
      trig_pending  <= '0;
      trig_overflow <= 1'b0;
      evt_id        <= '0;
      bc_q          <= '0;
    end else begin
      mr_req  <= (mr_req  & ~start_mr)  | mr_rise;
      bcr_req <= (bcr_req & ~start_bcr) | bcr_rise | ((AUTO_BCR != 0) & bc_wrap);
      ecr_req <= (ecr_req & ~start_ecr) | ecr_rise;

      if (trig_acc & ~start_trig)      trig_pending <= trig_pending + TP_W'(1);
      else if (~trig_acc & start_trig) trig_pending <= trig_pending - TP_W'(1);

      // A drop in the same cycle as an MR start leaves the flag set.
      if (trig_rise & ~trig_acc) trig_overflow <= 1'b1;
      else if (start_mr)         trig_overflow <= 1'b0;

      if (start_mr | start_ecr) evt_id <= '0;
      else if (start_trig)      evt_id <= evt_id + EVT_W'(1);

      if (start_mr | start_bcr | bc_wrap) bc_q <= '0;
      else                                bc_q <= bc_q + BC_W'(1);
    end
  end

  assign fpga_bcr   = bc_wrap;
  assign encode_ttc = (state_q == S_SEND) ? shreg_q[CODE_W-1 -: ENC_W] : '0;
  assign busy       = (state_q != S_IDLE) | any_req;

endmodule

// File: tb/tb_ttc_symbol_generator.sv
module tb_ttc_symbol_generator;

  logic clk_40 = 1'b0;
  always #5 clk_40 = ~clk_40;

  // u0: default parameters
  logic        rst0 = 1'b1, trg0 = 1'b0, bcr0 = 1'b0, ecr0 = 1'b0, mr0 = 1'b0;
  logic [1:0]  enc0;
  logic        fb0, busy0, ov0;
  logic [3:0]  tp0;
  logic [11:0] evt0;

  // u1: shallow queue, gap and automatic BCR
  logic        rst1 = 1'b1, trg1 = 1'b0, bcr1 = 1'b0, ecr1 = 1'b0, mr1 = 1'b0;
  logic [1:0]  enc1;
  logic        fb1, busy1, ov1;
  logic [1:0]  tp1;
  logic [11:0] evt1;

  ttc_symbol_generator u0 (
    .clk_40(clk_40), .rst_40(rst0), .trigger(trg0), .bc_reset(bcr0),
    .event_reset(ecr0), .master_reset(mr0), .encode_ttc(enc0), .fpga_bcr(fb0),
    .busy(busy0), .trig_pending(tp0), .trig_overflow(ov0), .evt_id(evt0)
  );

  ttc_symbol_generator #(.TRIG_DEPTH(2), .AUTO_BCR(1), .GAP(2)) u1 (
    .clk_40(clk_40), .rst_40(rst1), .trigger(trg1), .bc_reset(bcr1),
    .event_reset(ecr1), .master_reset(mr1), .encode_ttc(enc1), .fpga_bcr(fb1),
    .busy(busy1), .trig_pending(tp1), .trig_overflow(ov1), .evt_id(evt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_40);
    #1;
  endtask

  initial begin
    logic [31:0] seq;
    logic [19:0] seq6;
    int cnt;
    int peak;

    // reset state
    tick();
    chk("rst_enc", {30'd0, enc0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_tp", {28'd0, tp0}, 32'd0);
    chk("rst_evt", {20'd0, evt0}, 32'd0);
    chk("rst_fbcr", {31'd0, fb0}, 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // free-run bunch-crossing wrap, auto BCR on u1
    cnt = 0;
    while (cnt < 4000) begin
      tick(); cnt++;
      if (fb0) break;
    end
    chk("bc_first_wrap", cnt, 3563);
    chk("bc_u1_wrap", {31'd0, fb1}, 32'd1);
    tick();
    chk("bc_pulse_width", {31'd0, fb0}, 32'd0);
    chk("auto_bcr_busy", {31'd0, busy1}, 32'd1);
    chk("auto_bcr_idle_slice", {30'd0, enc1}, 32'd0);
    seq = 32'h00000099;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("auto_bcr_slice", {30'd0, enc1}, {30'd0, seq[7-2*i -: 2]});
    end
    tick();
    chk("auto_bcr_gap", {30'd0, enc1}, 32'd0);
    cnt = 6;
    while (cnt < 4000) begin
      tick(); cnt++;
      if (fb0) break;
    end
    chk("bc_period", cnt, 3564);

    // single trigger
    trg0 = 1'b1;
    tick();
    chk("t1_pending", {28'd0, tp0}, 32'd1);
    chk("t1_idle_enc", {30'd0, enc0}, 32'd0);
    trg0 = 1'b0;
    seq = 32'h00000081;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_slice", {30'd0, enc0}, {30'd0, seq[7-2*i -: 2]});
      if (i == 0) begin
        chk("t1_pending_start", {28'd0, tp0}, 32'd0);
        chk("t1_evt", {20'd0, evt0}, 32'd1);
      end
    end
    tick();
    chk("t1_after", {30'd0, enc0}, 32'd0);
    chk("t1_busy", {31'd0, busy0}, 32'd0);

    // MR, BCR, ECR, TRIG back-to-back
    trg0 = 1'b1; mr0 = 1'b1; ecr0 = 1'b1;
    tick();
    trg0 = 1'b0; mr0 = 1'b0; ecr0 = 1'b0;
    seq = 32'hE799A581;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) bcr0 = 1'b1;
      if (i == 5) bcr0 = 1'b0;
      tick();
      chk("t2_slice", {30'd0, enc0}, {30'd0, seq[31-2*i -: 2]});
      if (i == 0) chk("t2_mr_evt", {20'd0, evt0}, 32'd0);
    end
    tick();
    chk("t2_after", {30'd0, enc0}, 32'd0);
    chk("t2_busy", {31'd0, busy0}, 32'd0);
    chk("t2_evt", {20'd0, evt0}, 32'd1);
    cnt = 12;
    while (cnt < 4000) begin
      tick(); cnt++;
      if (fb0) break;
    end
    chk("t2_bc_cleared", cnt, 3563);

    // GAP=2 with two triggers queued
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    trg1 = 1'b1;
    tick();
    chk("t6_pending", {30'd0, tp1}, 32'd1);
    trg1 = 1'b0;
    tick();
    chk("t6_slice0", {30'd0, enc1}, 32'd2);
    chk("t6_evt1", {20'd0, evt1}, 32'd1);
    trg1 = 1'b1;
    tick();
    chk("t6_slice1", {30'd0, enc1}, 32'd0);
    chk("t6_pending2", {30'd0, tp1}, 32'd1);
    trg1 = 1'b0;
    seq6 = 20'b00_01_00_00_10_00_00_01_00_00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_seq", {30'd0, enc1}, {30'd0, seq6[19-2*i -: 2]});
      if (i == 9) chk("t6_gap_busy", {31'd0, busy1}, 32'd1);
    end
    tick();
    chk("t6_idle", {31'd0, busy1}, 32'd0);
    chk("t6_evt", {20'd0, evt1}, 32'd2);

    // trigger queue overflow, depth 2
    peak = 0;
    for (int c = 0; c < 20; c++) begin
      trg1 = (c % 2 == 0);
      tick();
      if (int'(tp1) > peak) peak = int'(tp1);
      if (c == 4) chk("t3_no_ovf_yet", {31'd0, ov1}, 32'd0);
      if (c == 6) chk("t3_ovf", {31'd0, ov1}, 32'd1);
    end
    trg1 = 1'b0;
    chk("t3_peak", peak, 2);
    cnt = 0;
    while (cnt < 100) begin
      tick(); cnt++;
      if (!busy1) break;
    end
    chk("t3_drain", cnt, 12);
    chk("t3_evt", {20'd0, evt1}, 32'd7);
    chk("t3_ovf_sticky", {31'd0, ov1}, 32'd1);
    mr1 = 1'b1;
    tick();
    mr1 = 1'b0;
    tick();
    chk("t3_mr_slice", {30'd0, enc1}, 32'd3);
    chk("t3_mr_ovf", {31'd0, ov1}, 32'd0);
    chk("t3_mr_evt", {20'd0, evt1}, 32'd0);

    // reset mid-symbol
    trg0 = 1'b1;
    tick();
    trg0 = 1'b0;
    tick();
    tick();
    #2;
    rst0 = 1'b1;
    #1;
    chk("t5_enc", {30'd0, enc0}, 32'd0);
    chk("t5_busy", {31'd0, busy0}, 32'd0);
    chk("t5_evt", {20'd0, evt0}, 32'd0);
    chk("t5_fbcr", {31'd0, fb0}, 32'd0);
    chk("t5_ovf", {31'd0, ov0}, 32'd0);
    tick();
    rst0 = 1'b0;
    trg0 = 1'b1;
    tick();
    chk("t5_pending", {28'd0, tp0}, 32'd1);
    trg0 = 1'b0;
    seq = 32'h00000081;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_slice", {30'd0, enc0}, {30'd0, seq[7-2*i -: 2]});
    end
    tick();
    chk("t5_after", {30'd0, enc0}, 32'd0);
    chk("t5_evt_after", {20'd0, evt0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
